// File: rtl/noc_inject_arbiter.sv
// Round-robin, packet-locking arbiter sharing one NoC injection port.
// Optional per-requester packet counters when ARB_STATS_EN is defined.
module noc_inject_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_last,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              full,
  input  logic              almost_full,
  output logic              out_write,
  output logic [W-1:0]      out_data,
  output logic              locked,
  output logic [IDW-1:0]    owner,
  input  logic [IDW-1:0]    stat_sel,
  output logic [15:0]       stat_cnt
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state, state_nx;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win, sel;
  logic            found, grant_ok;
  logic            can_send, xfer, last;
  logic [W-1:0]    data_sel;
  logic [NREQ-1:0] ready;

  // Accounts for the flit already on its way into the router FIFO.
  assign can_send = ~pause &
    ~((out_write & almost_full) | (~out_write & full));

  // Reverse scan so the nearest requester after ptr wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        win   = IDW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    sel      = win;
    grant_ok = found;
    if (state == LOCKED) begin
      sel      = owner;
      grant_ok = 1'b1;
    end
    ready = '0;
    if (grant_ok && can_send) ready[sel] = 1'b1;
    xfer     = |(ready & req_valid);
    last     = req_last[sel];
    data_sel = req_data[int'(sel)*W +: W];
    unique case (state)
      IDLE:   if (xfer && !last) state_nx = LOCKED;
      LOCKED: if (xfer && last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= IDW'(NREQ - 1);
      owner     <= IDW'(NREQ - 1);
      out_write <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      out_write <= xfer;
      if (xfer) begin
        out_data <= data_sel;
        owner    <= sel;
        if (last) ptr <= sel;
      end
    end
  end

  assign req_ready = ready;
  assign locked    = (state == LOCKED);

`ifdef ARB_STATS_EN
  logic [15:0] cnt [NREQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (xfer && last && cnt[sel] != 16'hFFFF) begin
      cnt[sel] <= cnt[sel] + 16'd1;
    end
  end

  assign stat_cnt = (int'(stat_sel) < NREQ) ? cnt[stat_sel] : 16'h0000;
`else
  logic stat_unused;
  assign stat_unused = ^stat_sel;
  assign stat_cnt    = 16'h0000;
`endif

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Directed scoreboard bench for noc_inject_arbiter.
// Expected flits are queued at accept time and popped when out_write fires.
module tb_noc_inject_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              pause;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_last;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              full;
  logic              almost_full;
  logic              out_write;
  logic [W-1:0]      out_data;
  logic              locked;
  logic [IDW-1:0]    owner;
  logic [IDW-1:0]    stat_sel;
  logic [15:0]       stat_cnt;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] last_data;

  noc_inject_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
    .clk(clk), .reset(reset), .pause(pause),
    .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready),
    .full(full), .almost_full(almost_full),
    .out_write(out_write), .out_data(out_data),
    .locked(locked), .owner(owner),
    .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int seq);
    for (int i = 0; i < NREQ; i++) begin
      logic [10:0] s;
      s = 11'(seq + i);
      req_data[i*W +: W] = {s, 2'(i), 2'(3 - i), 1'b1};
    end
  endtask

  // g = expected grant this cycle, -1 for no transfer.
  task automatic step(input int g, input string tag);
    logic [NREQ-1:0] er;
    logic [W-1:0] e;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'(er));
    if (g >= 0) sb.push_back(req_data[g*W +: W]);
    @(posedge clk);
    #1;
    chk({tag, ".write"}, 32'(out_write), 32'(g >= 0));
    if (g >= 0) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 32'(1), 32'(0));
      end else begin
        e = sb.pop_front();
        chk({tag, ".data"}, 32'(out_data), 32'(e));
        last_data = e;
      end
      chk({tag, ".owner"}, 32'(owner), 32'(g));
    end else begin
      chk({tag, ".hold"}, 32'(out_data), 32'(last_data));
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.write", 32'(out_write), 32'(0));
    chk("rst.data", 32'(out_data), 32'(0));
    chk("rst.locked", 32'(locked), 32'(0));
    chk("rst.owner", 32'(owner), 32'(NREQ - 1));
    chk("rst.stat", 32'(stat_cnt), 32'(0));
    last_data = '0;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pause = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    full = 1'b0; almost_full = 1'b0; stat_sel = '0;
    last_data = '0;
    do_reset();
    @(posedge clk);
    #1;

    // Round robin over four single-flit requesters.
    req_valid = 4'b1111; req_last = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      set_data(n * 8);
      step(n % NREQ, "rr");
    end

    // req1 locks the port for a 3-flit packet.
    req_valid = 4'b0111; req_last = 4'b0101;
    set_data(100); step(1, "pkt1");
    chk("pkt1.locked", 32'(locked), 32'(1));
    set_data(110); step(1, "pkt2");
    chk("pkt2.locked", 32'(locked), 32'(1));
    req_last = 4'b0111;
    set_data(120); step(1, "pkt3");
    chk("pkt3.locked", 32'(locked), 32'(0));
    set_data(130); step(2, "after_pkt");

    // Back-pressure through almost_full and full.
    req_valid = 4'b0001; req_last = 4'b0001;
    set_data(200); step(0, "af0");
    almost_full = 1'b1;
    step(-1, "af_stall");
    set_data(210); step(0, "af_one");
    step(-1, "af_stall2");
    full = 1'b1;
    step(-1, "both_full");
    full = 1'b0; almost_full = 1'b0;

    // Pause for five cycles.
    pause = 1'b1;
    for (int n = 0; n < 5; n++) step(-1, "pause");
    pause = 1'b0;
    set_data(220); step(0, "resume");

    // Reset while req2 holds a lock.
    req_valid = 4'b0100; req_last = 4'b0000;
    set_data(300); step(2, "lock2");
    chk("lock2.locked", 32'(locked), 32'(1));
    reset = 1'b1;
    #1;
    chk("arst.locked", 32'(locked), 32'(0));
    chk("arst.owner", 32'(owner), 32'(NREQ - 1));
    chk("arst.write", 32'(out_write), 32'(0));
    last_data = '0;
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b0101; req_last = 4'b0101;
    set_data(310); step(0, "post_rst0");
    set_data(320); step(2, "post_rst2");

    // Packet counters for req3.
    req_valid = '0;
    do_reset();
    req_valid = 4'b1000; req_last = 4'b1000;
    set_data(400); step(3, "st_a");
    set_data(410); step(3, "st_b");
    req_last = 4'b0000;
    for (int n = 0; n < 3; n++) begin
      set_data(420 + n); step(3, "st_pkt");
    end
    req_last = 4'b1000;
    set_data(430); step(3, "st_end");
    chk("st_end.locked", 32'(locked), 32'(0));
    req_valid = '0;
    stat_sel = 2'd3;
    #1;
`ifdef ARB_STATS_EN
    chk("stat3", 32'(stat_cnt), 32'(3));
`else
    chk("stat3", 32'(stat_cnt), 32'(0));
`endif
    stat_sel = 2'd0;
    #1;
    chk("stat0", 32'(stat_cnt), 32'(0));
    step(-1, "idle");
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
